// File: rtl/menu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : menu_pkg                                                     |
// | Purpose : Shared state encoding and default item mask for the pocket   |
// |           LED board menu controller.                                   |
// | Contents: ST_* state codes, menu_state_e enum, C_ITEM_MASK_ALL.        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package menu_pkg;

  localparam logic [1:0] ST_BROWSE = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_EXIT   = 2'd2;

  typedef enum logic [1:0] {
    S_BROWSE = ST_BROWSE,
    S_RUN    = ST_RUN,
    S_EXIT   = ST_EXIT
  } menu_state_e;

  // Wide enough for the largest menu; the top slices off N_ITEMS bits.
  localparam logic [15:0] C_ITEM_MASK_ALL = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/menu_key_edge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : menu_key_edge                                                |
// | Purpose : Brings one asynchronous key level into the clk domain and    |
// |           emits a one-cycle pulse on each rising edge.                 |
// | Ports   : clk, rst_n (async active-low), key (async level in),         |
// |           pulse (one clk cycle high per press).                        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module menu_key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= key;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  // A held key produces a single pulse; release produces none.
  assign pulse = r_sync2 & ~r_sync2_d;

endmodule
`default_nettype wire

// File: rtl/menu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : menu_ctrl                                                    |
// | Purpose : Menu controller: browses enabled items with next/prev,       |
// |           launches the highlighted item with select, and returns to    |
// |           browsing on the item's exit request or a user abort.         |
// | Ports   : clk, rst_n (async active-low)                                |
// |           key_sel/key_next/key_prev/key_abort : async key levels       |
// |           back_req[N_ITEMS]  : per-item exit request (clk domain)      |
// |           en_sub_n[N_ITEMS]  : one-cold active-low item enable         |
// |           top_idx[IDX_W]     : highlighted item                        |
// |           in_sub             : item running or exiting                 |
// |           launch             : one-cycle pulse on item enable          |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int                 N_ITEMS   = 8,
  parameter int                 IDX_W     = $clog2(N_ITEMS),
  parameter logic [N_ITEMS-1:0] ITEM_MASK = C_ITEM_MASK_ALL[N_ITEMS-1:0],
  parameter bit                 WRAP      = 1'b1,
  parameter bit                 ABORT_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_sel,
  input  logic               key_next,
  input  logic               key_prev,
  input  logic               key_abort,
  input  logic [N_ITEMS-1:0] back_req,
  output logic [N_ITEMS-1:0] en_sub_n,
  output logic [IDX_W-1:0]   top_idx,
  output logic               in_sub,
  output logic               launch
);

  logic w_sel;
  logic w_next;
  logic w_prev;
  logic w_abort;

  menu_key_edge u_key_sel   (.clk(clk), .rst_n(rst_n), .key(key_sel),   .pulse(w_sel));
  menu_key_edge u_key_next  (.clk(clk), .rst_n(rst_n), .key(key_next),  .pulse(w_next));
  menu_key_edge u_key_prev  (.clk(clk), .rst_n(rst_n), .key(key_prev),  .pulse(w_prev));
  menu_key_edge u_key_abort (.clk(clk), .rst_n(rst_n), .key(key_abort), .pulse(w_abort));

  menu_state_e        r_state;
  menu_state_e        w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [N_ITEMS-1:0] r_en_n;
  logic [N_ITEMS-1:0] w_en_n_nxt;
  logic               r_in_sub;
  logic               w_in_sub_nxt;
  logic               r_launch;
  logic               w_launch_nxt;

  // Nearest enabled item above (up=1) or below (up=0) cur. Without wrap a
  // candidate that falls off either end is skipped, so the index saturates.
  function automatic logic [IDX_W-1:0] f_step(input logic [IDX_W-1:0] cur,
                                              input logic             up);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] ci;
    logic             found;
    int               cand;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k < N_ITEMS; k++) begin
      cand = up ? (int'(cur) + k) : (int'(cur) - k);
      if (WRAP) begin
        if (cand >= N_ITEMS) cand = cand - N_ITEMS;
        else if (cand < 0)   cand = cand + N_ITEMS;
      end
      ci = cand[IDX_W-1:0];
      if (!found && cand >= 0 && cand < N_ITEMS && ITEM_MASK[ci]) begin
        res   = ci;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [N_ITEMS-1:0] w_cur_onehot;
  logic               w_cur_back;

  assign w_cur_onehot = {{(N_ITEMS-1){1'b0}}, 1'b1} << r_idx;
  assign w_cur_back   = back_req[r_idx];

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_en_n_nxt   = '1;
    w_in_sub_nxt = r_in_sub;
    w_launch_nxt = 1'b0;
    case (r_state)
      S_BROWSE: begin
        w_in_sub_nxt = 1'b0;
        // Select wins over any simultaneous browse key; abort has no
        // meaning here. next+prev together cancel out.
        if (w_sel) begin
          w_state_nxt  = S_RUN;
          w_en_n_nxt   = ~w_cur_onehot;
          w_in_sub_nxt = 1'b1;
          w_launch_nxt = 1'b1;
        end else if (w_next && !w_prev) begin
          w_idx_nxt = f_step(r_idx, 1'b1);
        end else if (w_prev && !w_next) begin
          w_idx_nxt = f_step(r_idx, 1'b0);
        end
      end
      S_RUN: begin
        w_in_sub_nxt = 1'b1;
        if (w_cur_back || (ABORT_EN && w_abort)) begin
          w_state_nxt = S_EXIT;
        end else begin
          w_en_n_nxt = ~w_cur_onehot;
        end
      end
      S_EXIT: begin
        // Holding here until the request drops keeps a still-asserted
        // back_req from being seen again and key pulses from relaunching.
        w_in_sub_nxt = 1'b1;
        if (!w_cur_back) begin
          w_state_nxt  = S_BROWSE;
          w_in_sub_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_BROWSE;
        w_in_sub_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BROWSE;
      r_idx    <= '0;
      r_en_n   <= '1;
      r_in_sub <= 1'b0;
      r_launch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_en_n   <= w_en_n_nxt;
      r_in_sub <= w_in_sub_nxt;
      r_launch <= w_launch_nxt;
    end
  end

  assign en_sub_n = r_en_n;
  assign top_idx  = r_idx;
  assign in_sub   = r_in_sub;
  assign launch   = r_launch;

endmodule
`default_nettype wire

// File: tb/tb_menu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_menu_ctrl                                                 |
// | Purpose : Self-checking bench for menu_ctrl. Two instances share the   |
// |           inputs: one with defaults, one with a sparse mask, no wrap   |
// |           and abort disabled. Both are compared every cycle against a  |
// |           behavioural model of the menu.                               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sel = 1'b0;
  logic       key_next = 1'b0;
  logic       key_prev = 1'b0;
  logic       key_abort = 1'b0;
  logic [7:0] back_req = 8'h00;

  logic [7:0] en0, en1;
  logic [2:0] idx0, idx1;
  logic       in0, in1, l0, l1;

  always #5 clk = ~clk;

  menu_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .key_sel(key_sel), .key_next(key_next),
    .key_prev(key_prev), .key_abort(key_abort), .back_req(back_req),
    .en_sub_n(en0), .top_idx(idx0), .in_sub(in0), .launch(l0)
  );

  menu_ctrl #(
    .N_ITEMS(8), .ITEM_MASK(8'b1010_0101), .WRAP(1'b0), .ABORT_EN(1'b0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_sel(key_sel), .key_next(key_next),
    .key_prev(key_prev), .key_abort(key_abort), .back_req(back_req),
    .en_sub_n(en1), .top_idx(idx1), .in_sub(in1), .launch(l1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = browsing, 1 = application running, 2 = application leaving
  bit [7:0] m_mask  [2] = '{8'hFF, 8'hA5};
  bit       m_wrap  [2] = '{1'b1, 1'b0};
  bit       m_abort [2] = '{1'b1, 1'b0};
  int       m_mode  [2];
  int       m_idx   [2];
  bit       m_launch[2];
  // key levels seen at the last three edges, {abort,prev,next,sel}
  bit [3:0] h1, h2, h3;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = 0; m_idx[m] = 0; m_launch[m] = 1'b0;
    end
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  function automatic int model_move(input int m, input int cur, input bit up);
    int q[$];
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (m_mask[m][i]) q.push_back(i);
    for (int i = 0; i < q.size(); i++) if (q[i] == cur) p = i;
    if (up) return (p + 1 < q.size()) ? q[p+1] : (m_wrap[m] ? q[0] : cur);
    else    return (p > 0) ? q[p-1] : (m_wrap[m] ? q[q.size()-1] : cur);
  endfunction

  task automatic model_step();
    bit [3:0] p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // A press is acted on two edges after the key is first sampled high.
    p  = h2 & ~h3;
    h3 = h2;
    h2 = h1;
    h1 = {key_abort, key_prev, key_next, key_sel};
    for (int m = 0; m < 2; m++) begin
      m_launch[m] = 1'b0;
      case (m_mode[m])
        0: begin
          if (p[0]) begin
            m_mode[m] = 1; m_launch[m] = 1'b1;
          end else if (p[1] != p[2]) begin
            m_idx[m] = model_move(m, m_idx[m], p[1]);
          end
        end
        1: if (back_req[m_idx[m]] || (m_abort[m] && p[3])) m_mode[m] = 2;
        default: if (!back_req[m_idx[m]]) m_mode[m] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [7:0] e;
    logic [7:0] en_o;
    logic [2:0] idx_o;
    logic       in_o, l_o;
    for (int m = 0; m < 2; m++) begin
      en_o  = m ? en1 : en0;
      idx_o = m ? idx1 : idx0;
      in_o  = m ? in1 : in0;
      l_o   = m ? l1 : l0;
      e = 8'hFF;
      if (m_mode[m] == 1) e[m_idx[m]] = 1'b0;
      check_eq($sformatf("top_idx%0d", m), idx_o, m_idx[m]);
      check_eq($sformatf("en_sub_n%0d", m), en_o, e);
      check_eq($sformatf("in_sub%0d", m), in_o, m_mode[m] != 0);
      check_eq($sformatf("launch%0d", m), l_o, m_launch[m]);
      check_eq($sformatf("onecold%0d", m), ($countones(~en_o) <= 1), 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_keys(input bit [3:0] k);
    {key_abort, key_prev, key_next, key_sel} = k;
  endtask

  task automatic press(input bit [3:0] k);
    set_keys(k);
    repeat (4) tick();
    set_keys(4'b0000);
    repeat (3) tick();
  endtask

  localparam bit [3:0] K_SEL = 4'b0001, K_NEXT = 4'b0010,
                       K_PREV = 4'b0100, K_ABT = 4'b1000;

  int exp1[4] = '{2, 5, 7, 7};

  initial begin
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Browsing forward: default instance wraps, sparse one saturates.
    for (int i = 0; i < 9; i++) begin
      press(K_NEXT);
      check_eq("seq_next0", idx0, (i + 1) % 8);
    end

    // Reset, prev at 0 on the saturating instance, then four nexts.
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1; tick();
    press(K_PREV);
    check_eq("prev_sat1", idx1, 0);
    check_eq("prev_wrap0", idx0, 7);
    for (int i = 0; i < 4; i++) begin
      press(K_NEXT);
      check_eq("seq_next1", idx1, exp1[i]);
    end

    // Launch at idx 3 / idx 7, foreign exit request, own request held.
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1; tick();
    repeat (3) press(K_NEXT);
    press(K_SEL);
    check_eq("launch_en0", en0, 8'hF7);
    back_req = 8'h20; repeat (3) tick();
    back_req = 8'h08; repeat (5) tick();
    check_eq("exit_hold_in0", in0, 1);
    back_req = 8'h00; repeat (2) tick();
    back_req = 8'h80; repeat (3) tick();
    back_req = 8'h00; repeat (2) tick();

    // In RUN: browse/select keys ignored; abort only on instance 0.
    press(K_SEL);
    press(K_NEXT);
    press(K_SEL);
    press(K_ABT);
    check_eq("abort_in1", in1, 1);
    back_req = 8'hFF; repeat (2) tick();
    back_req = 8'h00; repeat (2) tick();

    // Select together with next, then next with prev.
    press(K_SEL | K_NEXT);
    back_req = 8'hFF; repeat (2) tick();
    back_req = 8'h00; repeat (2) tick();
    press(K_NEXT | K_PREV);

    // Asynchronous reset mid-run, between clock edges.
    press(K_SEL);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_en0", en0, 8'hFF);
    check_eq("async_en1", en1, 8'hFF);
    check_eq("async_idx0", idx0, 0);
    check_eq("async_in0", in0, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Random key and exit-request activity.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) key_sel   = ~key_sel;
      if ($urandom_range(0, 5) == 0) key_next  = ~key_next;
      if ($urandom_range(0, 5) == 0) key_prev  = ~key_prev;
      if ($urandom_range(0, 9) == 0) key_abort = ~key_abort;
      if ($urandom_range(0, 15) == 0) back_req = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) back_req = 8'h00;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert ($countones(~en0) <= 1 && $countones(~en1) <= 1);
    end
  end

endmodule
`default_nettype wire

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
- Parametrised top-level menu controller for the pocket LED board.
- Browses N_ITEMS sub-applications with next/prev keys, skipping masked items.
- Launches the selected application with the select key by driving its active-low enable.
- Returns to browsing when that application requests exit, or when the user aborts.
- Sits between the key scanner and the per-application blocks; single clock domain, fully synchronous edge handling.

Parameters:
- N_ITEMS, 8, number of sub-applications; range 2..16.
- IDX_W, $clog2(N_ITEMS), width of the menu index.
- ITEM_MASK, all ones (N_ITEMS bits), bit i = 1 means item i is selectable. Bit 0 must be 1.
- WRAP, 1, 1 = browsing wraps at the ends; 0 = browsing saturates at the first/last enabled item.
- ABORT_EN, 1, 1 = key_abort forces exit from a running application.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_sel  in  1  select key, level, asynchronous to clk
- key_next  in  1  next-item key, level, asynchronous
- key_prev  in  1  previous-item key, level, asynchronous
- key_abort  in  1  abort key, level, asynchronous
- back_req  in  N_ITEMS  per-application exit request, level, synchronous to clk
- en_sub_n  out  N_ITEMS  active-low one-cold enable; at most one bit low
- top_idx  out  IDX_W  currently highlighted item
- in_sub  out  1  1 while an application is enabled or exiting
- launch  out  1  one-cycle pulse when an application is enabled

Behaviour:
- Reset: the asynchronous assertion of rst_n forces:
  - state = BROWSE, top_idx = 0, en_sub_n = all ones, in_sub = 0, launch = 0;
  - all key synchroniser and edge-detect flops = 0.
- Key path, per key:
  - 2-flop synchroniser, then rising-edge detect (sync2 & ~sync2_d).
  - A key high before edge E0 produces an internal pulse during E1..E2; registered outputs change at E2.
  - A held key gives exactly one pulse; release gives none.
- All outputs are registered.
- State machine: BROWSE, RUN, EXIT.
- BROWSE:
  - Priority of key pulses in the same cycle: sel > abort (ignored in BROWSE) > next/prev.
  - next and prev together: ignored, no index change.
  - next: top_idx moves to the nearest higher enabled index.
    - No higher enabled index and WRAP=1: move to the lowest enabled index.
    - No higher enabled index and WRAP=0: stay.
  - prev: mirror of next.
  - Single enabled item: top_idx never changes.
  - sel: go to RUN. en_sub_n[top_idx] <= 0, in_sub <= 1, launch <= 1 for exactly one cycle. top_idx is unchanged.
- RUN:
  - next, prev and sel pulses are ignored; those keys belong to the application.
  - back_req[top_idx] = 1: go to EXIT, en_sub_n <= all ones. back_req of other channels is ignored.
  - key_abort pulse with ABORT_EN=1: same transition as back_req. With ABORT_EN=0: ignored.
  - back_req already high on the first RUN cycle: exit on the next edge. The enable is low for exactly one cycle.
- EXIT:
  - en_sub_n stays all ones and in_sub stays 1.
  - Wait for back_req[top_idx] = 0, then go to BROWSE with in_sub <= 0. top_idx is retained.
  - Key pulses during EXIT are dropped. This prevents immediate re-launch.
- rst_n asserted in any state: immediate return to the reset values. The running application is disabled asynchronously.
- Invariant: popcount(~en_sub_n) <= 1 at all times. en_sub_n low implies state == RUN.

Decomposition:
- Package menu_pkg holds:
  - state encoding localparams ST_BROWSE = 2'd0, ST_RUN = 2'd1, ST_EXIT = 2'd2;
  - the default ITEM_MASK constant.
- Sub-module menu_key_edge (2-flop sync + rising-edge pulse, clk/rst_n) is instantiated once per key, four times in total.
- Next/prev enabled-index search stays in menu_ctrl as a combinational function.

Test Plan:
- Reset, then 9 next presses with N_ITEMS=8, WRAP=1 -> top_idx sequence 1..7, 0, 1; en_sub_n = 8'hFF throughout.
- WRAP=0, ITEM_MASK=8'b1010_0101, prev at idx 0 then 4 next presses -> top_idx stays 0, then 2, 5, 7, 7.
- idx=3, sel -> 2 edges later en_sub_n = 8'hF7, launch high exactly 1 cycle, in_sub = 1. Raise back_req[5] -> no change. Raise back_req[3] -> next edge en_sub_n = 8'hFF. Hold back_req[3] high 5 cycles -> state stays EXIT. Drop it -> in_sub = 0.
- In RUN, press next and sel -> top_idx and en_sub_n unchanged. key_abort with ABORT_EN=1 -> EXIT then BROWSE. Repeat with ABORT_EN=0 -> no effect.
- sel and next pulses in the same cycle -> launch of the current idx, top_idx unchanged. next and prev together -> no change.
- Assert rst_n=0 mid-RUN between clock edges -> en_sub_n = all ones immediately, top_idx = 0. Check the one-cold invariant with an assertion over a 10k-cycle random key run.
